// File: rtl/regfile_mp_sb.sv
// Multi-port integer register file with optional write-to-read bypass and a
// per-register busy scoreboard. Decode claims a destination, writeback clears it.

// One read port: combinational lookup of storage, bypass and busy masking.
module regfile_mp_sb_rdport #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32,
    parameter int NUM_WRITE  = 2,
    parameter int BYPASS     = 1,
    parameter int ZERO_REG   = 1
) (
    input  logic                                        i_rst,
    input  logic [ADDR_WIDTH-1:0]                       i_addr,
    input  logic [(1<<ADDR_WIDTH)-1:0][DATA_WIDTH-1:0]  i_regs,
    input  logic [(1<<ADDR_WIDTH)-1:0]                  i_busy,
    input  logic [NUM_WRITE-1:0]                        i_wr_en,
    input  logic [NUM_WRITE*ADDR_WIDTH-1:0]             i_wr_addr,
    input  logic [NUM_WRITE*DATA_WIDTH-1:0]             i_wr_data,
    input  logic                                        i_claim_en,
    input  logic [ADDR_WIDTH-1:0]                       i_claim_addr,
    output logic [DATA_WIDTH-1:0]                       o_data,
    output logic                                        o_busy
);
    logic                  w_hit;
    logic                  w_claim;
    logic [DATA_WIDTH-1:0] w_byp_data;

    // Scan write ports in ascending order so the highest-index hit wins the bypass.
    always_comb begin
        w_hit      = 1'b0;
        w_byp_data = '0;
        for (int w = 0; w < NUM_WRITE; w++) begin
            if (i_wr_en[w] && (i_wr_addr[w*ADDR_WIDTH +: ADDR_WIDTH] == i_addr)) begin
                w_hit      = 1'b1;
                w_byp_data = i_wr_data[w*DATA_WIDTH +: DATA_WIDTH];
            end
        end
        w_claim = i_claim_en && (i_claim_addr == i_addr);
        o_data  = i_regs[i_addr];
        o_busy  = i_busy[i_addr];
        if ((BYPASS != 0) && w_hit) begin
            o_data = w_byp_data;
            // A same-cycle claim means a new producer takes over, so stay busy.
            if (!w_claim)
                o_busy = 1'b0;
        end
        // Outputs follow the async reset immediately, bypass included.
        if (i_rst || ((ZERO_REG != 0) && (i_addr == '0))) begin
            o_data = '0;
            o_busy = 1'b0;
        end
    end
endmodule

module regfile_mp_sb #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32,
    parameter int NUM_READ   = 2,
    parameter int NUM_WRITE  = 2,
    parameter int BYPASS     = 1,
    parameter int ZERO_REG   = 1
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [NUM_READ*ADDR_WIDTH-1:0]  rd_addr_i,
    output logic [NUM_READ*DATA_WIDTH-1:0]  rd_data_o,
    output logic [NUM_READ-1:0]             rd_busy_o,
    input  logic [NUM_WRITE-1:0]            wr_en_i,
    input  logic [NUM_WRITE*ADDR_WIDTH-1:0] wr_addr_i,
    input  logic [NUM_WRITE*DATA_WIDTH-1:0] wr_data_i,
    input  logic                            claim_en_i,
    input  logic [ADDR_WIDTH-1:0]           claim_addr_i,
    output logic [ADDR_WIDTH:0]             busy_cnt_o
);
    localparam int DEPTH = 1 << ADDR_WIDTH;

    logic [DEPTH-1:0][DATA_WIDTH-1:0] r_regs;
    logic [DEPTH-1:0]                 r_busy;
    logic [ADDR_WIDTH:0]              r_busy_cnt;
    logic [DEPTH-1:0]                 w_wr_hit;
    logic [DEPTH-1:0]                 w_claim_hit;
    logic [NUM_WRITE-1:0]             w_wr_ok;
    logic [ADDR_WIDTH:0]              w_pop;

    // Decode write/claim addresses into one-hot register masks; r0 is inert when hardwired.
    always_comb begin
        w_wr_hit    = '0;
        w_claim_hit = '0;
        for (int w = 0; w < NUM_WRITE; w++) begin
            w_wr_ok[w] = wr_en_i[w] &&
                         !((ZERO_REG != 0) && (wr_addr_i[w*ADDR_WIDTH +: ADDR_WIDTH] == '0));
            if (w_wr_ok[w])
                w_wr_hit[wr_addr_i[w*ADDR_WIDTH +: ADDR_WIDTH]] = 1'b1;
        end
        if (claim_en_i && !((ZERO_REG != 0) && (claim_addr_i == '0)))
            w_claim_hit[claim_addr_i] = 1'b1;
    end

    // Popcount of the current busy vector, registered on the next edge.
    always_comb begin
        w_pop = '0;
        for (int i = 0; i < DEPTH; i++)
            w_pop = w_pop + {{ADDR_WIDTH{1'b0}}, r_busy[i]};
    end

    // Storage, scoreboard and busy counter; later write ports override earlier ones.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_regs     <= '0;
            r_busy     <= '0;
            r_busy_cnt <= '0;
        end else begin
            for (int w = 0; w < NUM_WRITE; w++)
                if (w_wr_ok[w])
                    r_regs[wr_addr_i[w*ADDR_WIDTH +: ADDR_WIDTH]] <= wr_data_i[w*DATA_WIDTH +: DATA_WIDTH];
            r_busy     <= w_claim_hit | (r_busy & ~w_wr_hit);
            r_busy_cnt <= w_pop;
        end
    end

    assign busy_cnt_o = r_busy_cnt;

    for (genvar p = 0; p < NUM_READ; p++) begin : g_rd
        regfile_mp_sb_rdport #(
            .ADDR_WIDTH (ADDR_WIDTH),
            .DATA_WIDTH (DATA_WIDTH),
            .NUM_WRITE  (NUM_WRITE),
            .BYPASS     (BYPASS),
            .ZERO_REG   (ZERO_REG)
        ) u_rd (
            .i_rst        (rst),
            .i_addr       (rd_addr_i[p*ADDR_WIDTH +: ADDR_WIDTH]),
            .i_regs       (r_regs),
            .i_busy       (r_busy),
            .i_wr_en      (wr_en_i),
            .i_wr_addr    (wr_addr_i),
            .i_wr_data    (wr_data_i),
            .i_claim_en   (claim_en_i),
            .i_claim_addr (claim_addr_i),
            .o_data       (rd_data_o[p*DATA_WIDTH +: DATA_WIDTH]),
            .o_busy       (rd_busy_o[p])
        );
    end
endmodule
